// File: rtl/axi_lite_pkg.sv
// Shared constants and types for the AXI-Lite SRAM slave: response codes,
// read FSM states and the stall LFSR taps and step function.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axi_lite_sram_slave_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 24
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [3:0]            wstrb;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );

endinterface

// File: rtl/sram_bytewrite.sv
// DEPTH x DATA_WIDTH storage with per-byte write enables and an
// asynchronous read port; contents are intentionally not reset.
module sram_bytewrite #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = 10
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        waddr_i,
    input  logic [DATA_WIDTH/8-1:0] wbe_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [IDX_W-1:0]        raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] merged;

    // Read-modify-write keeps the array to a single write process.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            assign merged[gi*8 +: 8] = wbe_i[gi] ? wdata_i[gi*8 +: 8]
                                                 : mem[waddr_i][gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= merged;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI-Lite single-beat SRAM slave with configurable read latency and SLVERR
// for out-of-range words. Define AXI_SRAM_STALL_EN for LFSR-driven stalls.
module axi_lite_sram_slave
    import axi_lite_pkg::*;
#(
    parameter int          DATA_WIDTH   = 24,
    parameter int          ADDR_WIDTH   = 16,
    parameter int          DEPTH        = 1024,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
    input logic        clk,
    input logic        rst,
    axi_lite_if.slave  axi
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    logic stall_hs;
    logic stall_resp;

`ifdef AXI_SRAM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= STALL_SEED;
        else     lfsr_q <= lfsr_step(lfsr_q);
    end

    assign stall_hs   = lfsr_q[0];
    assign stall_resp = lfsr_q[1];
`else
    assign stall_hs   = 1'b0;
    assign stall_resp = 1'b0;
`endif

    wire unused_ok = &{1'b0, axi.wlast, axi.wstrb, STALL_SEED};

    // ---------------- write path ----------------
    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [NB-1:0]         w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic                  b_pend_q, b_pend_d;
    logic [1:0]            bresp_q, bresp_d;

    logic b_busy, aw_rdy, w_rdy, aw_fire, w_fire, b_fire, commit, wr_in_range;

    assign b_busy      = bvalid_q | b_pend_q;
    assign aw_rdy      = !rst && !aw_held_q && !b_busy && !stall_hs;
    assign w_rdy       = !rst && !w_held_q && !b_busy && !stall_hs;
    assign aw_fire     = axi.awvalid && aw_rdy;
    assign w_fire      = axi.wvalid && w_rdy;
    assign b_fire      = bvalid_q && axi.bready;
    assign commit      = aw_held_q && w_held_q && !b_busy;
    assign wr_in_range = 32'(aw_addr_q) < DEPTH;

    always_comb begin
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        b_pend_d  = b_pend_q;
        bresp_d   = bresp_q;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        if (aw_fire) begin
            aw_held_d = 1'b1;
            aw_addr_d = axi.awaddr;
        end
        if (w_fire) begin
            w_held_d = 1'b1;
            w_data_d = axi.wdata;
            w_strb_d = axi.wstrb[NB-1:0];
        end
        if (b_fire) begin
            bvalid_d = 1'b0;
            bresp_d  = RESP_OKAY;
        end
        if (b_pend_q) begin
            b_pend_d = 1'b0;
            bvalid_d = 1'b1;
        end
        if (commit) begin
            bresp_d = wr_in_range ? RESP_OKAY : RESP_SLVERR;
            if (stall_resp) b_pend_d = 1'b1;
            else            bvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            b_pend_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            b_pend_q  <= b_pend_d;
            bresp_q   <= bresp_d;
        end
    end

    // ---------------- read path ----------------
    rd_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  r_hold_q, r_hold_d;

    logic                  ar_rdy, r_vld, ar_fire, r_fire, capture, rd_in_range, fwd_hit;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] mem_rdata, cap_data;

    assign ar_fire  = axi.arvalid && ar_rdy;
    assign r_fire   = r_vld && axi.rready;
    assign capture  = ((state_q == R_IDLE) && ar_fire && (READ_LATENCY == 1)) ||
                      ((state_q == R_WAIT) && (cnt_q == '0));
    assign cap_addr = (state_q == R_IDLE) ? axi.araddr : raddr_q;

    assign rd_in_range = 32'(cap_addr) < DEPTH;
    assign fwd_hit     = commit && wr_in_range && (aw_addr_q == cap_addr);

    // Write-first: a commit landing on the capture edge wins per strobed byte.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_fwd
            assign cap_data[gi*8 +: 8] = (fwd_hit && w_strb_q[gi]) ? w_data_q[gi*8 +: 8]
                                                                   : mem_rdata[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_q <= R_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            R_IDLE:  if (ar_fire) state_d = (READ_LATENCY == 1) ? R_RESP : R_WAIT;
            R_WAIT:  if (cnt_q == '0) state_d = R_RESP;
            R_RESP:  if (r_fire) state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    always_comb begin
        ar_rdy = 1'b0;
        r_vld  = 1'b0;
        case (state_q)
            R_IDLE:  ar_rdy = !rst && !stall_hs;
            R_RESP:  r_vld  = !r_hold_q;
            default: ;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        raddr_d  = raddr_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        r_hold_d = 1'b0;
        if ((state_q == R_IDLE) && ar_fire) begin
            raddr_d = axi.araddr;
            cnt_d   = CNT_W'(READ_LATENCY - 1);
        end else if ((state_q == R_WAIT) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (capture) begin
            rdata_d  = rd_in_range ? cap_data : '0;
            rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
            r_hold_d = stall_resp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            raddr_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            r_hold_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            r_hold_q <= r_hold_d;
        end
    end

    sram_bytewrite #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (commit && wr_in_range),
        .waddr_i (IDX_W'(aw_addr_q)),
        .wbe_i   (w_strb_q),
        .wdata_i (w_data_q),
        .raddr_i (IDX_W'(cap_addr)),
        .rdata_o (mem_rdata)
    );

    assign axi.awready = aw_rdy;
    assign axi.wready  = w_rdy;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.arready = ar_rdy;
    assign axi.rvalid  = r_vld;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = r_vld;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Scoreboard bench for axi_lite_sram_slave: directed cases then random
// single-beat traffic checked against an array-based memory model.
module tb_axi_lite_sram_slave;
    localparam int DW    = 24;
    localparam int AW    = 16;
    localparam int DEPTH = 1024;
    localparam int RL    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_lite_sram_slave #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL),
        .STALL_SEED   (16'hACE1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .axi (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } rexp_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] model [DEPTH];
    logic [1:0]    bq [$];
    rexp_t         rq [$];
    rexp_t         mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [3:0]    strb);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < DW / 8; i++)
            if (strb[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    // Monitor: pops the expected response whenever a B or R handshake is visible.
    always @(negedge clk) begin
        if (!rst && bus.bvalid && bus.bready) begin
            check("b_expected_pending", 32'(bq.size() > 0), 1);
            if (bq.size() > 0) check("bresp", bus.bresp, bq.pop_front());
        end
        if (!rst && bus.rvalid && bus.rready) begin
            check("r_expected_pending", 32'(rq.size() > 0), 1);
            if (rq.size() > 0) begin
                mon_e = rq.pop_front();
                check("rdata", bus.rdata, mon_e.data);
                check("rresp", bus.rresp, mon_e.resp);
                check("rlast", bus.rlast, 1);
            end
        end
    end

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input int lead, input int bp);
        bit         aw_done = 0, w_done = 0, aw_f, w_f;
        int         c = 0, wc = 0;
        bit         inr = (32'(addr) < DEPTH);
        logic [1:0] er  = inr ? 2'b00 : 2'b10;
        if (inr) model[addr] = merge(model[addr], data, strb);
        bq.push_back(er);
        @(posedge clk); #1;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wlast   = 1'b1;
        bus.awvalid = (lead <= 0);
        bus.wvalid  = (lead >= 0);
        while (!(aw_done && w_done) && c < 50) begin
            @(negedge clk);
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            if (w_done && !aw_done) check("wready_low_while_held", bus.wready, 0);
            if (aw_done && !w_done) check("awready_low_while_held", bus.awready, 0);
            @(posedge clk); #1;
            if (aw_f) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_f)  begin w_done = 1;  bus.wvalid  = 1'b0; end
            c++;
            if (lead > 0 && c == lead && !aw_done)  bus.awvalid = 1'b1;
            if (lead < 0 && c == -lead && !w_done)  bus.wvalid  = 1'b1;
        end
        check("write_accepted", 32'(aw_done && w_done), 1);
        do begin
            @(negedge clk);
            wc++;
        end while (!bus.bvalid && wc < 20);
        check("b_latency", wc, 2);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("b_hold_valid", bus.bvalid, 1);
            check("b_hold_resp", bus.bresp, er);
            check("b_hold_awready", bus.awready, 0);
            check("b_hold_wready", bus.wready, 0);
        end
        @(posedge clk); #1;
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        @(negedge clk);
        check("b_dropped", bus.bvalid, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int bp);
        bit    done = 0, f;
        int    c = 0, wc = 0;
        bit    inr = (32'(addr) < DEPTH);
        rexp_t e;
        e.data = inr ? model[addr] : '0;
        e.resp = inr ? 2'b00 : 2'b10;
        rq.push_back(e);
        @(posedge clk); #1;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!done && c < 50) begin
            @(negedge clk);
            f = bus.arvalid && bus.arready;
            @(posedge clk); #1;
            if (f) begin done = 1; bus.arvalid = 1'b0; end
            c++;
        end
        check("read_accepted", 32'(done), 1);
        do begin
            @(negedge clk);
            wc++;
        end while (!bus.rvalid && wc < 20);
        check("r_latency", wc, RL + 1);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("r_hold_valid", bus.rvalid, 1);
            check("r_hold_data", bus.rdata, e.data);
            check("r_hold_arready", bus.arready, 0);
        end
        @(posedge clk); #1;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        @(negedge clk);
        check("r_dropped", bus.rvalid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rexp_t ce;
        bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0;
        bus.wstrb = '0;  bus.wlast = 0;   bus.bready = 0; bus.arvalid = 0;
        bus.araddr = '0; bus.rready = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", bus.awready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rlast", bus.rlast, 0);
        check("rst_outputs", {bus.bresp, bus.rresp, bus.rdata}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst_aw", bus.awready, 1);
        check("ready_after_rst_ar", bus.arready, 1);

        for (int a = 0; a < 16; a++) do_write(AW'(a), DW'($urandom), 4'hF, 0, 0);

        do_write(16'h0005, 24'hA1B2C3, 4'b0111, 0, 0);
        do_read(16'h0005, 0);
        do_write(16'h0010, 24'h123456, 4'b0111, 3, 0);
        do_read(16'h0010, 0);
        do_write(16'h0020, 24'hFFFFFF, 4'b0111, 0, 0);
        do_write(16'h0020, 24'h000000, 4'b0010, -1, 0);
        do_read(16'h0020, 0);
        check("partial_strobe_model", model[16'h0020], 24'hFF00FF);
        do_write(16'h0400, 24'hDEAD01, 4'b0111, 0, 0);
        do_read(16'h0000, 0);
        do_read(16'h0400, 0);
        do_read(16'hFFFF, 0);
        do_write(16'h0007, 24'h5A5A5A, 4'b0111, -2, 5);
        do_read(16'h0007, 5);

        // Read capture edge coincides with the commit of a write to the same word.
        do_write(16'h0009, 24'h111111, 4'b0111, 0, 0);
        @(posedge clk); #1;
        bus.araddr = 16'h0009; bus.arvalid = 1'b1;
        @(negedge clk);
        check("coll_arready", bus.arready, 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.awaddr = 16'h0009; bus.wdata = 24'hAABBCC; bus.wstrb = 4'b0101;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        model[9] = merge(model[9], 24'hAABBCC, 4'b0101);
        bq.push_back(2'b00);
        ce.data = model[9]; ce.resp = 2'b00;
        rq.push_back(ce);
        @(negedge clk);
        check("coll_aw_w_ready", {bus.awready, bus.wready}, 2'b11);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(posedge clk); #1;
        bus.bready = 1'b1; bus.rready = 1'b1;
        @(negedge clk);
        check("coll_rvalid", bus.rvalid, 1);
        check("coll_bvalid", bus.bvalid, 1);
        @(posedge clk); #1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        do_read(16'h0009, 0);

        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] ra;
            ra = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 16'hFFFF))
                                             : AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0)
                do_write(ra, DW'($urandom), 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)));
            else
                do_read(ra, int'($urandom_range(0, 2)));
        end

        // Reset while the read is in R_WAIT discards it.
        @(posedge clk); #1;
        bus.araddr = 16'h0003; bus.arvalid = 1'b1;
        @(negedge clk);
        check("rstwait_arready", bus.arready, 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rready = 1'b1;
        @(negedge clk);
        check("arready_after_reset", bus.arready, 1);
        for (int i = 0; i < 6; i++) begin
            check("rvalid_after_reset", bus.rvalid, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rready = 1'b0;
        do_read(16'h0003, 0);

        repeat (5) @(posedge clk);
        #1;
        check("b_queue_drained", bq.size(), 0);
        check("r_queue_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
